// File: rtl/dispatch_scoreboard_if.sv
// Fetch, writeback and dispatch bundle for the dispatch scoreboard.
//   master : upstream fetch/writeback driver and dispatch consumer
//   slave  : the scoreboard itself
// Fetch   : fetch_valid/fetch_ready handshake plus fu, rd, rs1, rs2, rd_en fields
// WB      : wb_valid, wb_fu, wb_rd (clears a matching pending-writer tag)
// Dispatch: disp_valid, fust_en (one-hot FU), disp_rd, disp_t1/disp_t2 source tags
interface dispatch_scoreboard_if #(
    parameter int unsigned NUM_FU = 5,
    parameter int unsigned NREGS  = 32
);
    localparam int unsigned FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned REG_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned TAG_W = $clog2(NUM_FU + 1);

    logic              fetch_valid;
    logic              fetch_ready;
    logic [FU_W-1:0]   fetch_fu;
    logic [REG_W-1:0]  fetch_rd;
    logic [REG_W-1:0]  fetch_rs1;
    logic [REG_W-1:0]  fetch_rs2;
    logic              fetch_rd_en;

    logic              wb_valid;
    logic [FU_W-1:0]   wb_fu;
    logic [REG_W-1:0]  wb_rd;

    logic              disp_valid;
    logic [NUM_FU-1:0] fust_en;
    logic [REG_W-1:0]  disp_rd;
    logic [TAG_W-1:0]  disp_t1;
    logic [TAG_W-1:0]  disp_t2;

    modport master (
        output fetch_valid, fetch_fu, fetch_rd, fetch_rs1, fetch_rs2, fetch_rd_en,
        output wb_valid, wb_fu, wb_rd,
        input  fetch_ready, disp_valid, fust_en, disp_rd, disp_t1, disp_t2
    );

    modport slave (
        input  fetch_valid, fetch_fu, fetch_rd, fetch_rs1, fetch_rs2, fetch_rd_en,
        input  wb_valid, wb_fu, wb_rd,
        output fetch_ready, disp_valid, fust_en, disp_rd, disp_t1, disp_t2
    );
endinterface

// File: rtl/dispatch_scoreboard.sv
// Single-entry dispatch stage with a result-status table (one pending-writer tag
// per architectural register). Tag 0 means no pending writer, tag k means FU k-1.
// Ports:
//   CLK, nRST  : clock, asynchronous active-low reset
//   flush      : drop the latched instruction and any same-cycle fetch
//   freeze     : hold the stage (no fetch, no dispatch); writebacks still clear
//   fu_busy    : per-FU status-table occupied
//   bus        : fetch / writeback / dispatch bundle (slave side)
//   stall_cnt  : saturating count of cycles a latched instruction failed to dispatch
// Dispatch outputs are decoded from the latch and the current cycle's
// writeback/busy inputs so a same-cycle writeback can release a WAW hazard.
module dispatch_scoreboard #(
    parameter int unsigned NUM_FU = 5,
    parameter int unsigned NREGS  = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 flush,
    input  logic                 freeze,
    input  logic [NUM_FU-1:0]    fu_busy,
    dispatch_scoreboard_if.slave bus,
    output logic [15:0]          stall_cnt
);
    localparam int unsigned FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned REG_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned TAG_W = $clog2(NUM_FU + 1);
    // One bit wider than a tag so wb_fu+1 cannot wrap onto tag 0
    localparam int unsigned CMP_W = TAG_W + 1;

    logic              latch_valid;
    logic [FU_W-1:0]   latch_fu;
    logic [REG_W-1:0]  latch_rd;
    logic [REG_W-1:0]  latch_rs1;
    logic [REG_W-1:0]  latch_rs2;
    logic              latch_rd_en;

    logic [TAG_W-1:0]  rst_tab [NREGS];
    logic [TAG_W-1:0]  rst_byp [NREGS];

    logic              wb_clear_c;
    logic              fu_valid_c;
    logic              fu_busy_sel_c;
    logic [NUM_FU-1:0] fu_onehot_c;
    logic              waw_c;
    logic              dispatch_fire_c;
    logic              fetch_ready_c;
    logic              fetch_fire_c;
    logic              tag_write_c;

    // Writeback only clears the entry if it still names the writing FU
    always_comb begin
        wb_clear_c = bus.wb_valid && (bus.wb_rd != '0) &&
                     (CMP_W'(rst_tab[bus.wb_rd]) == CMP_W'(bus.wb_fu) + CMP_W'(1));
    end

    // Table view with the same-cycle writeback already applied; entry 0 reads 0
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            rst_byp[i] = rst_tab[i];
            if ((i == 0) || (wb_clear_c && (bus.wb_rd == REG_W'(i)))) begin
                rst_byp[i] = '0;
            end
        end
    end

    // FU decode; an out-of-range FU index never matches and so never dispatches
    always_comb begin
        fu_valid_c    = 1'b0;
        fu_busy_sel_c = 1'b0;
        fu_onehot_c   = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (latch_fu == FU_W'(i)) begin
                fu_valid_c     = 1'b1;
                fu_busy_sel_c  = fu_busy[i];
                fu_onehot_c[i] = 1'b1;
            end
        end
    end

    // Hazard check and handshake
    always_comb begin
        waw_c           = latch_rd_en && (latch_rd != '0) && (rst_byp[latch_rd] != '0);
        dispatch_fire_c = latch_valid && !freeze && !flush && fu_valid_c &&
                          !fu_busy_sel_c && !waw_c;
        fetch_ready_c   = !freeze && (!latch_valid || dispatch_fire_c);
        fetch_fire_c    = bus.fetch_valid && fetch_ready_c && !flush;
        tag_write_c     = dispatch_fire_c && latch_rd_en && (latch_rd != '0);
    end

    assign bus.fetch_ready = fetch_ready_c;
    assign bus.disp_valid  = dispatch_fire_c;
    assign bus.fust_en     = dispatch_fire_c ? fu_onehot_c : '0;
    assign bus.disp_rd     = dispatch_fire_c ? latch_rd : '0;
    assign bus.disp_t1     = dispatch_fire_c ? rst_byp[latch_rs1] : '0;
    assign bus.disp_t2     = dispatch_fire_c ? rst_byp[latch_rs2] : '0;

    // Input latch: flush beats a fetch, a fetch refills behind a dispatch
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            latch_valid <= 1'b0;
            latch_fu    <= '0;
            latch_rd    <= '0;
            latch_rs1   <= '0;
            latch_rs2   <= '0;
            latch_rd_en <= 1'b0;
        end else if (flush) begin
            latch_valid <= 1'b0;
        end else if (fetch_fire_c) begin
            latch_valid <= 1'b1;
            latch_fu    <= bus.fetch_fu;
            latch_rd    <= bus.fetch_rd;
            latch_rs1   <= bus.fetch_rs1;
            latch_rs2   <= bus.fetch_rs2;
            latch_rd_en <= bus.fetch_rd_en;
        end else if (dispatch_fire_c) begin
            latch_valid <= 1'b0;
        end
    end

    // Result-status table; a new writer's tag overrides a same-cycle clear
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rst_tab[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                if (tag_write_c && (latch_rd == REG_W'(i))) begin
                    rst_tab[i] <= TAG_W'(latch_fu) + TAG_W'(1);
                end else if (wb_clear_c && (bus.wb_rd == REG_W'(i))) begin
                    rst_tab[i] <= '0;
                end
            end
        end
    end

    // Stall counter; flush cycles are not counted as stalls
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (latch_valid && !dispatch_fire_c && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_dispatch_scoreboard.sv
// Self-checking bench for dispatch_scoreboard: directed vector table, an
// asynchronous-reset sequence, then randomized traffic against a reference model.
module tb_dispatch_scoreboard;
    localparam int unsigned NUM_FU = 5;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned FU_W   = 3;
    localparam int unsigned REG_W  = 5;
    localparam int          RAND_CYCLES = 3000;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              flush;
    logic              freeze;
    logic [NUM_FU-1:0] fu_busy;
    logic [15:0]       stall_cnt;

    dispatch_scoreboard_if #(.NUM_FU(NUM_FU), .NREGS(NREGS)) bus ();

    dispatch_scoreboard #(.NUM_FU(NUM_FU), .NREGS(NREGS)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .freeze    (freeze),
        .fu_busy   (fu_busy),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // One directed cycle: inputs, then expected outputs in that same cycle
    typedef struct {
        int fv, fu, rd, rs1, rs2, en, busy, wbv, wbfu, wbrd, fl, fz;
        int dv, fust, drd, t1, t2, rdy, stall;
    } vec_t;
    vec_t tbl[$];

    // Reference model state
    int m_rst [NREGS];
    int m_lv, m_fu, m_rd, m_rs1, m_rs2, m_en, m_stall;

    function automatic void add(input int fv, fu, rd, rs1, rs2, en, busy, wbv, wbfu, wbrd,
                                fl, fz, dv, fust, drd, t1, t2, rdy, stall);
        vec_t v;
        v.fv = fv; v.fu = fu; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.en = en;
        v.busy = busy; v.wbv = wbv; v.wbfu = wbfu; v.wbrd = wbrd; v.fl = fl; v.fz = fz;
        v.dv = dv; v.fust = fust; v.drd = drd; v.t1 = t1; v.t2 = t2; v.rdy = rdy;
        v.stall = stall;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int fv, fu, rd, rs1, rs2, en, busy, wbv, wbfu, wbrd, fl, fz);
        bus.fetch_valid = (fv != 0);
        bus.fetch_fu    = FU_W'(fu);
        bus.fetch_rd    = REG_W'(rd);
        bus.fetch_rs1   = REG_W'(rs1);
        bus.fetch_rs2   = REG_W'(rs2);
        bus.fetch_rd_en = (en != 0);
        fu_busy         = NUM_FU'(busy);
        bus.wb_valid    = (wbv != 0);
        bus.wb_fu       = FU_W'(wbfu);
        bus.wb_rd       = REG_W'(wbrd);
        flush           = (fl != 0);
        freeze          = (fz != 0);
    endtask

    task automatic check_outs(input string tag, input int dv, fust, drd, t1, t2, rdy, st);
        chk({tag, " disp_valid"},  int'(bus.disp_valid),  dv);
        chk({tag, " fust_en"},     int'(bus.fust_en),     fust);
        chk({tag, " disp_rd"},     int'(bus.disp_rd),     drd);
        chk({tag, " disp_t1"},     int'(bus.disp_t1),     t1);
        chk({tag, " disp_t2"},     int'(bus.disp_t2),     t2);
        chk({tag, " fetch_ready"}, int'(bus.fetch_ready), rdy);
        chk({tag, " stall_cnt"},   int'(stall_cnt),       st);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        next_cycle();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_rst[i] = 0;
        m_lv = 0; m_fu = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_en = 0; m_stall = 0;
    endtask

    // One random cycle checked against the model, then the model advances
    task automatic rand_cycle(input int cyc);
        int fv, fu, rd, rs1, rs2, en, busy, wbv, wbfu, wbrd, fl, fz;
        int wbclr, fire, rdy, hazard;
        int byp [NREGS];
        fv   = ($urandom_range(0, 9) < 7) ? 1 : 0;
        fu   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
        rd   = int'($urandom_range(0, 7));
        rs1  = int'($urandom_range(0, 7));
        rs2  = int'($urandom_range(0, 7));
        en   = ($urandom_range(0, 4) != 0) ? 1 : 0;
        busy = int'($urandom & $urandom & 32'h1F);
        wbv  = int'($urandom_range(0, 1));
        wbrd = int'($urandom_range(0, 7));
        wbfu = (m_rst[wbrd] != 0 && $urandom_range(0, 3) != 0) ? m_rst[wbrd] - 1
                                                                : int'($urandom_range(0, 7));
        fl   = ($urandom_range(0, 24) == 0) ? 1 : 0;
        fz   = ($urandom_range(0, 9) == 0) ? 1 : 0;
        drive(fv, fu, rd, rs1, rs2, en, busy, wbv, wbfu, wbrd, fl, fz);

        wbclr = (wbv != 0 && wbrd != 0 && m_rst[wbrd] == wbfu + 1) ? 1 : 0;
        for (int i = 0; i < NREGS; i++) byp[i] = m_rst[i];
        if (wbclr != 0) byp[wbrd] = 0;
        byp[0] = 0;
        hazard = (m_en != 0 && m_rd != 0 && byp[m_rd] != 0) ? 1 : 0;
        fire = (m_lv != 0 && fz == 0 && fl == 0 && m_fu < NUM_FU &&
                ((busy >> m_fu) & 1) == 0 && hazard == 0) ? 1 : 0;
        rdy  = (fz == 0 && (m_lv == 0 || fire != 0)) ? 1 : 0;

        #2;
        check_outs($sformatf("rand%0d", cyc), fire, (fire != 0) ? (1 << m_fu) : 0,
                   (fire != 0) ? m_rd : 0, (fire != 0) ? byp[m_rs1] : 0,
                   (fire != 0) ? byp[m_rs2] : 0, rdy, m_stall);

        if (wbclr != 0) m_rst[wbrd] = 0;
        if (fire != 0 && m_en != 0 && m_rd != 0) m_rst[m_rd] = m_fu + 1;
        if (m_lv != 0 && fire == 0 && fl == 0 && m_stall < 65535) m_stall++;
        if (fl != 0) m_lv = 0;
        else if (fv != 0 && rdy != 0) begin
            m_lv = 1; m_fu = fu; m_rd = rd; m_rs1 = rs1; m_rs2 = rs2; m_en = en;
        end else if (fire != 0) m_lv = 0;
        next_cycle();
    endtask

    initial begin
        // fv fu rd rs1 rs2 en busy wbv wbfu wbrd fl fz | dv fust drd t1 t2 rdy stall
        add(1,0,3,0,0,1, 0, 0,0,0, 0,0,  0, 0,0,0,0,1,0);
        add(1,1,4,0,0,1, 0, 0,0,0, 0,0,  1, 1,3,0,0,1,0);   // back-to-back dispatch
        add(1,3,0,3,4,0, 0, 0,0,0, 0,0,  1, 2,4,0,0,1,0);
        add(0,0,0,0,0,0, 0, 1,0,4, 0,0,  1, 8,0,1,2,1,0);   // RST[3]=1, RST[4]=2; stale wb ignored
        add(1,2,3,4,3,1, 0, 1,0,3, 0,0,  0, 0,0,0,0,1,0);   // wb clears RST[3]
        add(1,0,0,3,0,0, 0, 0,0,0, 0,0,  1, 4,3,2,0,1,0);
        add(1,1,5,0,0,1, 0, 0,0,0, 0,0,  1, 1,0,3,0,1,0);   // RAW tag: t1=3
        add(1,3,5,0,0,1, 0, 0,0,0, 0,0,  1, 2,5,0,0,1,0);   // RST[5]=2
        add(1,0,0,5,4,0, 0, 1,1,5, 0,0,  1, 8,5,0,0,1,0);   // WAW released by same-cycle wb
        add(0,0,0,0,0,0, 0, 0,0,0, 0,0,  1, 1,0,4,2,1,0);   // RST[5]=4
        add(1,1,6,0,0,1, 2, 0,0,0, 0,0,  0, 0,0,0,0,1,0);
        add(1,0,7,0,0,1, 2, 0,0,0, 0,0,  0, 0,0,0,0,0,0);   // structural stall x4
        add(1,0,7,0,0,1, 2, 0,0,0, 0,0,  0, 0,0,0,0,0,1);
        add(1,0,7,0,0,1, 2, 0,0,0, 0,0,  0, 0,0,0,0,0,2);
        add(1,0,7,0,0,1, 2, 0,0,0, 0,0,  0, 0,0,0,0,0,3);
        add(1,0,7,0,0,1, 0, 0,0,0, 0,0,  1, 2,6,0,0,1,4);   // fu_busy drops
        add(1,2,8,0,0,1, 0, 0,0,0, 1,0,  0, 0,0,0,0,0,4);   // flush latched + fetch
        add(1,2,0,7,6,0, 0, 0,0,0, 0,0,  0, 0,0,0,0,1,4);
        add(0,0,0,0,0,0, 0, 0,0,0, 0,0,  1, 4,0,0,2,1,4);   // RST[7]=0, RST[6]=2 kept
        add(1,3,8,5,0,1, 0, 0,0,0, 0,0,  0, 0,0,0,0,1,4);
        add(1,0,9,0,0,1, 0, 0,0,0, 0,1,  0, 0,0,0,0,0,4);   // freeze x3
        add(1,0,9,0,0,1, 0, 1,1,4, 0,1,  0, 0,0,0,0,0,5);   // wb clear during freeze
        add(1,0,9,0,0,1, 0, 0,0,0, 0,1,  0, 0,0,0,0,0,6);
        add(0,0,0,0,0,0, 0, 0,0,0, 0,0,  1, 8,8,4,0,1,7);
        add(1,4,0,4,8,0, 0, 0,0,0, 0,0,  0, 0,0,0,0,1,7);
        add(0,0,0,0,0,0, 0, 0,0,0, 0,0,  1,16,0,0,4,1,7);
        add(1,5,0,0,0,0, 0, 0,0,0, 0,0,  0, 0,0,0,0,1,7);   // fu == NUM_FU
        add(0,0,0,0,0,0, 0, 0,0,0, 0,0,  0, 0,0,0,0,0,7);
        add(0,0,0,0,0,0, 0, 0,0,0, 0,0,  0, 0,0,0,0,0,8);
        add(0,0,0,0,0,0, 0, 0,0,0, 1,0,  0, 0,0,0,0,0,9);
        add(0,0,0,0,0,0, 0, 0,0,0, 0,0,  0, 0,0,0,0,1,9);

        // Reset state
        idle();
        nRST = 1'b0;
        #3;
        check_outs("reset", 0, 0, 0, 0, 0, 1, 0);
        apply_reset();

        foreach (tbl[i]) begin
            drive(tbl[i].fv, tbl[i].fu, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].en,
                  tbl[i].busy, tbl[i].wbv, tbl[i].wbfu, tbl[i].wbrd, tbl[i].fl, tbl[i].fz);
            #2;
            check_outs($sformatf("row%0d", i), tbl[i].dv, tbl[i].fust, tbl[i].drd,
                       tbl[i].t1, tbl[i].t2, tbl[i].rdy, tbl[i].stall);
            next_cycle();
        end

        // Asynchronous reset mid-operation with RST[7]=3 and a valid latch
        drive(1, 2, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, 1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        #2;
        chk("arst setup fust_en", int'(bus.fust_en), 4);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        #2;
        chk("arst stalled disp_valid", int'(bus.disp_valid), 0);
        next_cycle();
        fu_busy = '0;
        #1;
        chk("arst pre disp_valid", int'(bus.disp_valid), 1);
        #1;
        nRST = 1'b0;
        #1;
        check_outs("arst async", 0, 0, 0, 0, 0, 1, 0);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        next_cycle();
        #2;
        check_outs("arst dropped", 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 7, 9, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        idle();
        #2;
        check_outs("arst RST7", 1, 1, 0, 0, 0, 1, 0);
        next_cycle();

        // Randomized traffic
        apply_reset();
        model_reset();
        for (int c = 0; c < RAND_CYCLES; c++) rand_cycle(c);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
